if_stage: RTL
=============

# if_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. Holds the PC, issues single-outstanding fetch requests to instruction memory, buffers a returned word while decode is stalled, and presents `instr_id` / `pc_id` / `pc_four_id` / `inst_vld_id` to the decode stage feeding the ID/EX register. Accepts PC redirects and flushes from the EX-stage branch resolution and stalls from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding, `addi x0,x0,0`.

Ports:
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rst`  in  1  one clock; reset is synchronous and active-high.
- `i_stall`  in  1  hold IF/ID contents (hazard unit).
- `i_flush`  in  1  squash IF/ID to a bubble.
- `i_pc_redirect`  in  1  load PC from `i_pc_target`; discard in-flight or buffered fetch.
- `i_pc_target`  in  32  redirect address.
- `o_imem_req`  out  1  one-cycle fetch request.
- `o_imem_addr`  out  32  fetch address, equal to the PC.
- `i_imem_rvalid`  in  1  response strobe; exactly one per request, at least 1 cycle after it.
- `i_imem_rdata`  in  32  instruction word, valid with `i_imem_rvalid`.
- `o_instr_id`  out  32  IF/ID instruction.
- `o_pc_id`  out  32  IF/ID PC.
- `o_pc_four_id`  out  32  IF/ID PC+4.
- `o_inst_vld_id`  out  1  IF/ID holds a real instruction.

## Operation
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, response wanted), DROP (request outstanding, response stale), BUF (word held, waiting for decode).
- IDLE:
  - If `i_pc_redirect`: no request; PC <= target; stay in IDLE.
  - Otherwise: `o_imem_req`=1 and `o_imem_addr`=PC; go to WAIT.
  - `o_imem_req` is combinational from state and is 0 in every other state and during `i_rst`.
- WAIT:
  - `i_imem_rvalid` with `i_pc_redirect`: discard the word; PC <= target; go to IDLE.
  - `i_imem_rvalid`, no redirect, `!i_stall`: load IF/ID with {rdata, PC, PC+4, vld=1}; PC <= PC+4; go to IDLE.
  - `i_imem_rvalid`, no redirect, `i_stall`: capture rdata and PC into the buffer; go to BUF.
  - Redirect without `i_imem_rvalid`: PC <= target; go to DROP.
- DROP:
  - `i_imem_rvalid`: discard the word; go to IDLE.
  - Redirect: PC <= target; stay in DROP.
- BUF:
  - Redirect: drop the buffer; PC <= target; go to IDLE.
  - `!i_stall`: load IF/ID from the buffer; PC <= PC+4; go to IDLE.
  - Otherwise: hold.
- IF/ID update priority: `i_rst` > `i_flush` > `i_stall` > load.
  - `i_flush` writes a bubble {`NOP_INSTR`, 0, 0, vld=0} regardless of stall. A buffer load or WAIT accept is suppressed in that cycle: the word stays in BUF (or enters BUF from WAIT). A redirect arriving with the flush discards it.
  - With `!i_stall` and no word delivered, IF/ID takes a bubble.
  - With `i_stall` and no flush, IF/ID holds.
- Arithmetic: PC+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0). No alignment check; the target is used verbatim.

## Timing
- Reset values:
  - State IDLE, PC=`RESET_PC`, buffer cleared.
  - `o_instr_id`=`NOP_INSTR`, `o_pc_id`=0, `o_pc_four_id`=0, `o_inst_vld_id`=0.
  - `o_imem_req`=0 and `o_imem_addr`=`RESET_PC` while `i_rst`=1.
- Reset mid-fetch forces IDLE. Any response arriving afterwards for the pre-reset request is the memory's responsibility; memory is reset together with the core.
- First request is issued in the first cycle after `i_rst` deasserts.
- Latency: request in cycle N, rvalid in cycle N+L (L≥1), IF/ID visible in cycle N+L+1, next request in cycle N+L+1.
- Throughput with L=1 is one instruction per 2 cycles.
- Redirect takes effect at the next edge; the first fetch from the target is issued at most 1 cycle after the stale response drains.

## Test plan
- Reset with `RESET_PC`=0, memory L=1 returning addr+32'h100: IF/ID sequence pc_id 0,4,8 with instr 0x100,0x104,0x108; bubbles (vld=0) between them; pc_four_id = pc_id+4.
- `i_stall` high for 3 cycles covering the rvalid of pc=8: word held in BUF, IF/ID unchanged. After release, IF/ID={0x108, 8, 12, 1} one cycle later, then the fetch of 12.
- `i_pc_redirect`=1 to 0x200 while in WAIT with L=3: response for the old PC discarded (never reaches IF/ID, vld stays 0). Next request addr=0x200.
- `i_flush` and `i_pc_redirect` together while BUF holds pc=0x10: IF/ID becomes {0x13,0,0,0}, buffer dropped, next request addr=target.
- Redirect to 32'hFFFF_FFFC: IF/ID pc_four_id=0, then the next request addr=0.
- `i_rst` asserted during WAIT: outputs return to reset values next cycle. After release the first request has addr=`RESET_PC`.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I core.
// Single-outstanding fetch, one-word skid buffer for decode stalls, redirect/flush handling.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_pc_redirect,
   input  logic [31:0] i_pc_target,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr_id,
   output logic [31:0] o_pc_id,
   output logic [31:0] o_pc_four_id,
   output logic        o_inst_vld_id
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP,
      S_BUF
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] buf_instr;
   logic        accept_wait;
   logic        accept_buf;
   logic        deliver;

   assign pc_plus4 = pc + 32'd4;

   // A word is only handed to IF/ID when neither flush nor stall blocks it;
   // otherwise it parks in (or stays in) the buffer.
   always_comb begin
      accept_wait = 1'b0;
      accept_buf  = 1'b0;
      deliver     = 1'b0;
      accept_wait = (state == S_WAIT) && i_imem_rvalid && !i_pc_redirect;
      accept_buf  = (state == S_BUF) && !i_pc_redirect;
      deliver     = (accept_wait || accept_buf) && !i_flush && !i_stall;
   end

   assign o_imem_req  = (state == S_IDLE) && !i_pc_redirect && !i_rst;
   assign o_imem_addr = i_rst ? RESET_PC : pc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         buf_instr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_pc_redirect) begin
                  pc <= i_pc_target;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_imem_rvalid) begin
                  if (i_pc_redirect) begin
                     pc    <= i_pc_target;
                     state <= S_IDLE;
                  end else if (deliver) begin
                     pc    <= pc_plus4;
                     state <= S_IDLE;
                  end else begin
                     buf_instr <= i_imem_rdata;
                     state     <= S_BUF;
                  end
               end else if (i_pc_redirect) begin
                  pc    <= i_pc_target;
                  state <= S_DROP;
               end
            end
            S_DROP: begin
               if (i_pc_redirect) begin
                  pc <= i_pc_target;
               end
               if (i_imem_rvalid) begin
                  state <= S_IDLE;
               end
            end
            S_BUF: begin
               if (i_pc_redirect) begin
                  pc        <= i_pc_target;
                  buf_instr <= '0;
                  state     <= S_IDLE;
               end else if (deliver) begin
                  pc    <= pc_plus4;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         o_instr_id    <= NOP_INSTR;
         o_pc_id       <= '0;
         o_pc_four_id  <= '0;
         o_inst_vld_id <= 1'b0;
      end else if (!i_stall) begin
         if (deliver) begin
            o_instr_id    <= accept_wait ? i_imem_rdata : buf_instr;
            o_pc_id       <= pc;
            o_pc_four_id  <= pc_plus4;
            o_inst_vld_id <= 1'b1;
         end else begin
            o_instr_id    <= NOP_INSTR;
            o_pc_id       <= '0;
            o_pc_four_id  <= '0;
            o_inst_vld_id <= 1'b0;
         end
      end
   end

endmodule
